// File: rtl/modexp_ctrl.sv
// Modular exponentiation controller: left-to-right square-and-multiply driving an external modular multiplier.
// Define MODEXP_SKIP_ZERO_EN to skip exponent bits above the leading one (results are unchanged).
module modexp_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] msg,
  input  logic [WIDTH-1:0] exp,
  input  logic [WIDTH-1:0] mod,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             err,
  output logic             mul_start,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  output logic [WIDTH-1:0] mul_n,
  input  logic             mul_done,
  input  logic [WIDTH-1:0] mul_r
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SQR_REQ  = 3'd1,
    SQR_WAIT = 3'd2,
    MUL_REQ  = 3'd3,
    MUL_WAIT = 3'd4,
    FIN      = 3'd5
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   m_q;
  logic [WIDTH-1:0]   e_q;
  logic [WIDTH-1:0]   n_q;
  logic [IDX_W-1:0]   bit_q;
  logic               sel_m_q;
  logic               ready_q;
  logic               done_q;
  logic               err_q;
  logic               mul_start_q;
  logic [WIDTH-1:0]   result_q;

`ifdef MODEXP_SKIP_ZERO_EN
  // Position of the leading one in the incoming exponent.
  logic [IDX_W-1:0] msb_c;
  always_comb begin
    msb_c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (exp[i]) msb_c = IDX_W'(i);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      r_q         <= WIDTH'(1);
      m_q         <= '0;
      e_q         <= '0;
      n_q         <= '0;
      bit_q       <= '0;
      sel_m_q     <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mul_start_q <= 1'b0;
      result_q    <= '0;
    end else begin
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mul_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            m_q     <= msg;
            e_q     <= exp;
            n_q     <= mod;
            r_q     <= WIDTH'(1);
            ready_q <= 1'b0;
            if (mod == '0 || msg >= mod) begin
              state_q  <= FIN;
              done_q   <= 1'b1;
              err_q    <= 1'b1;
              result_q <= '0;
            end else if (mod == WIDTH'(1)) begin
              state_q  <= FIN;
              done_q   <= 1'b1;
              result_q <= '0;
            end else begin
`ifdef MODEXP_SKIP_ZERO_EN
              // The square at the leading one acts on R=1, so go straight to its multiply.
              if (exp == '0) begin
                state_q  <= FIN;
                done_q   <= 1'b1;
                result_q <= WIDTH'(1);
              end else begin
                state_q     <= MUL_REQ;
                bit_q       <= msb_c;
                sel_m_q     <= 1'b1;
                mul_start_q <= 1'b1;
              end
`else
              state_q     <= SQR_REQ;
              bit_q       <= IDX_W'(WIDTH - 1);
              sel_m_q     <= 1'b0;
              mul_start_q <= 1'b1;
`endif
            end
          end
        end
        SQR_REQ: state_q <= SQR_WAIT;
        SQR_WAIT: begin
          if (mul_done) begin
            r_q <= mul_r;
            if (e_q[bit_q]) begin
              state_q     <= MUL_REQ;
              sel_m_q     <= 1'b1;
              mul_start_q <= 1'b1;
            end else if (bit_q == '0) begin
              state_q  <= FIN;
              done_q   <= 1'b1;
              result_q <= mul_r;
            end else begin
              state_q     <= SQR_REQ;
              bit_q       <= bit_q - IDX_W'(1);
              sel_m_q     <= 1'b0;
              mul_start_q <= 1'b1;
            end
          end
        end
        MUL_REQ: state_q <= MUL_WAIT;
        MUL_WAIT: begin
          if (mul_done) begin
            r_q <= mul_r;
            if (bit_q == '0) begin
              state_q  <= FIN;
              done_q   <= 1'b1;
              result_q <= mul_r;
            end else begin
              state_q     <= SQR_REQ;
              bit_q       <= bit_q - IDX_W'(1);
              sel_m_q     <= 1'b0;
              mul_start_q <= 1'b1;
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Operands come straight from flops and only change on a mul_done edge.
  assign mul_a     = r_q;
  assign mul_b     = sel_m_q ? m_q : r_q;
  assign mul_n     = n_q;
  assign mul_start = mul_start_q;
  assign ready     = ready_q;
  assign done      = done_q;
  assign err       = err_q;
  assign result    = result_q;

endmodule
